// File: rtl/branch_resolve_bht.sv
// rtl/branch_resolve_bht.sv - EX-stage branch resolution with 2-bit BHT predictor
//
// Resolves conditional branches from the ALU flags, raises a registered
// one-cycle flush plus redirect PC on a misprediction, and trains a table of
// 2-bit saturating counters that also serves combinational fetch predictions.
//
// Ports:
//   i_clk, i_rst_n       clock (rising edge), asynchronous active-low reset
//   i_f_pc               fetch PC used for the prediction lookup
//   o_f_pred_taken       combinational prediction for i_f_pc
//   i_ex_valid           EX slot holds a valid instruction
//   i_ex_is_branch       EX instruction is a conditional branch
//   i_ex_funct3          branch funct3
//   i_ex_pc/i_ex_target  EX PC and computed branch target
//   i_ex_pred_taken      prediction that travelled with the instruction
//   i_alu_zero/i_alu_lt  ALU comparison flags
//   i_stall              hold: do not resolve this cycle
//   o_flush              registered squash pulse
//   o_redirect_pc        registered restart PC, valid with o_flush
//   o_resolved_taken     registered actual outcome of the last resolved branch
//   o_br_count           (BRANCH_PERF_EN) resolved legal branch count
//   o_mispred_count      (BRANCH_PERF_EN) misprediction count
//
// Optional: define BRANCH_PERF_EN to add saturating performance counters.

module branch_resolve_bht #(
  parameter int IDX_BITS = 6,
  parameter int XLEN     = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [XLEN-1:0] i_f_pc,
  output logic            o_f_pred_taken,
  input  logic            i_ex_valid,
  input  logic            i_ex_is_branch,
  input  logic [2:0]      i_ex_funct3,
  input  logic [XLEN-1:0] i_ex_pc,
  input  logic [XLEN-1:0] i_ex_target,
  input  logic            i_ex_pred_taken,
  input  logic            i_alu_zero,
  input  logic            i_alu_lt,
  input  logic            i_stall,
  output logic            o_flush,
  output logic [XLEN-1:0] o_redirect_pc,
  output logic            o_resolved_taken
`ifdef BRANCH_PERF_EN
  ,
  output logic [31:0]     o_br_count,
  output logic [31:0]     o_mispred_count
`endif
);

  localparam int ENTRIES = 1 << IDX_BITS;

  // Counter states
  localparam logic [1:0] CTR_SN = 2'b00;
  localparam logic [1:0] CTR_WN = 2'b01;
  localparam logic [1:0] CTR_WT = 2'b10;
  localparam logic [1:0] CTR_ST = 2'b11;

  logic [1:0]          ctr_q [ENTRIES];
  logic [1:0]          ctr_d [ENTRIES];
  logic                flush_q, flush_d;
  logic [XLEN-1:0]     redirect_q, redirect_d;
  logic                resolved_q, resolved_d;

  logic [IDX_BITS-1:0] f_idx;
  logic [IDX_BITS-1:0] ex_idx;
  logic                res;
  logic                legal;
  logic                actual;
  logic                mispredict;
  logic [XLEN-1:0]     fallthrough_pc;

  // Only the index bits of the fetch PC matter for the lookup.
  logic                unused_f_pc;
  assign unused_f_pc = ^{i_f_pc[XLEN-1:IDX_BITS+2], i_f_pc[1:0]};

  assign f_idx  = i_f_pc[IDX_BITS+1:2];
  assign ex_idx = i_ex_pc[IDX_BITS+1:2];

  // Reads the registered table: a same-cycle update is not bypassed.
  assign o_f_pred_taken = ctr_q[f_idx][1];

  assign fallthrough_pc = i_ex_pc + {{(XLEN-3){1'b0}}, 3'd4};

  // Anything in EX while a flush is out is wrong-path and must be ignored.
  assign res = i_ex_valid & i_ex_is_branch & ~i_stall & ~flush_q;

  always_comb begin
    legal  = 1'b1;
    actual = 1'b0;
    case (i_ex_funct3)
      3'b000:          actual = i_alu_zero;
      3'b001:          actual = ~i_alu_zero;
      3'b100, 3'b110:  actual = i_alu_lt;
      3'b101, 3'b111:  actual = ~i_alu_lt;
      default: begin
        legal  = 1'b0;
        actual = 1'b0;
      end
    endcase
  end

  assign mispredict = res & legal & (actual != i_ex_pred_taken);

  always_comb begin
    ctr_d      = ctr_q;
    flush_d    = mispredict;
    redirect_d = redirect_q;
    resolved_d = resolved_q;

    if (mispredict) begin
      redirect_d = actual ? i_ex_target : fallthrough_pc;
    end

    if (res) begin
      resolved_d = actual;
    end

    if (res && legal) begin
      if (actual) begin
        if (ctr_q[ex_idx] != CTR_ST) begin
          ctr_d[ex_idx] = ctr_q[ex_idx] + 2'b01;
        end
      end else begin
        if (ctr_q[ex_idx] != CTR_SN) begin
          ctr_d[ex_idx] = ctr_q[ex_idx] - 2'b01;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= CTR_WN;
      end
      flush_q    <= 1'b0;
      redirect_q <= '0;
      resolved_q <= 1'b0;
    end else begin
      ctr_q      <= ctr_d;
      flush_q    <= flush_d;
      redirect_q <= redirect_d;
      resolved_q <= resolved_d;
    end
  end

  assign o_flush          = flush_q;
  assign o_redirect_pc    = redirect_q;
  assign o_resolved_taken = resolved_q;

  // Only referenced for documentation of the state encoding.
  logic [3:0] unused_states;
  assign unused_states = {CTR_WT, CTR_WN} ^ {CTR_ST, CTR_SN};

`ifdef BRANCH_PERF_EN
  logic [31:0] br_count_q, br_count_d;
  logic [31:0] mispred_count_q, mispred_count_d;

  always_comb begin
    br_count_d      = br_count_q;
    mispred_count_d = mispred_count_q;
    if (res && legal && (br_count_q != 32'hFFFF_FFFF)) begin
      br_count_d = br_count_q + 32'd1;
    end
    if (mispredict && (mispred_count_q != 32'hFFFF_FFFF)) begin
      mispred_count_d = mispred_count_q + 32'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      br_count_q      <= '0;
      mispred_count_q <= '0;
    end else begin
      br_count_q      <= br_count_d;
      mispred_count_q <= mispred_count_d;
    end
  end

  assign o_br_count      = br_count_q;
  assign o_mispred_count = mispred_count_q;
`endif

endmodule

// File: tb/tb_branch_resolve_bht.sv
// tb/tb_branch_resolve_bht.sv - randomized self-checking bench for branch_resolve_bht

module tb_branch_resolve_bht;

  logic        clk;
  logic        rst_n;
  logic [31:0] f_pc;
  logic        f_pred_taken;
  logic        ex_valid;
  logic        ex_is_branch;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_pc;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic        alu_zero;
  logic        alu_lt;
  logic        stall;
  logic        flush;
  logic [31:0] redirect_pc;
  logic        resolved_taken;
`ifdef BRANCH_PERF_EN
  logic [31:0] br_count;
  logic [31:0] mispred_count;
`endif

  branch_resolve_bht #(.IDX_BITS(6), .XLEN(32)) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_f_pc           (f_pc),
    .o_f_pred_taken   (f_pred_taken),
    .i_ex_valid       (ex_valid),
    .i_ex_is_branch   (ex_is_branch),
    .i_ex_funct3      (ex_funct3),
    .i_ex_pc          (ex_pc),
    .i_ex_target      (ex_target),
    .i_ex_pred_taken  (ex_pred_taken),
    .i_alu_zero       (alu_zero),
    .i_alu_lt         (alu_lt),
    .i_stall          (stall),
    .o_flush          (flush),
    .o_redirect_pc    (redirect_pc),
    .o_resolved_taken (resolved_taken)
`ifdef BRANCH_PERF_EN
    ,
    .o_br_count       (br_count),
    .o_mispred_count  (mispred_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: counters as plain integers 0..3
  int          m_ctr [64];
  bit          m_flush;
  logic [31:0] m_redir;
  bit          m_taken;
  int          m_br;
  int          m_mis;

  function automatic int tbl_idx(input logic [31:0] pc);
    return int'((pc >> 2) % 64);
  endfunction

  // -1 means funct3 is not a conditional branch encoding
  function automatic int outcome(input logic [2:0] f3, input bit z, input bit lt);
    case (f3)
      3'd0: return z ? 1 : 0;
      3'd1: return z ? 0 : 1;
      3'd4, 3'd6: return lt ? 1 : 0;
      3'd5, 3'd7: return lt ? 0 : 1;
      default: return -1;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_ctr[i] = 1;
    m_flush = 0;
    m_redir = 0;
    m_taken = 0;
    m_br    = 0;
    m_mis   = 0;
  endtask

  // Drive one cycle at the negedge, check the lookup, clock, then check registered outputs.
  task automatic step(input bit v, input bit br, input logic [2:0] f3,
                      input logic [31:0] pc, input logic [31:0] tgt, input bit pred,
                      input bit z, input bit lt, input bit st, input logic [31:0] fpc);
    int act;
    bit res;
    bit nflush;
    ex_valid = v; ex_is_branch = br; ex_funct3 = f3; ex_pc = pc; ex_target = tgt;
    ex_pred_taken = pred; alu_zero = z; alu_lt = lt; stall = st; f_pc = fpc;
    #1;
    check("f_pred", {31'd0, f_pred_taken}, {31'd0, m_ctr[tbl_idx(fpc)] >= 2});
    res    = v && br && !st && !m_flush;
    act    = outcome(f3, z, lt);
    nflush = 0;
    if (res && act >= 0) begin
      m_br++;
      if (act != int'(pred)) begin
        nflush  = 1;
        m_redir = (act == 1) ? tgt : pc + 32'd4;
        m_mis++;
      end
      if (act == 1) m_ctr[tbl_idx(pc)] = (m_ctr[tbl_idx(pc)] < 3) ? m_ctr[tbl_idx(pc)] + 1 : 3;
      else          m_ctr[tbl_idx(pc)] = (m_ctr[tbl_idx(pc)] > 0) ? m_ctr[tbl_idx(pc)] - 1 : 0;
    end
    if (res) m_taken = (act == 1);
    m_flush = nflush;
    @(posedge clk);
    @(negedge clk);
    check("flush", {31'd0, flush}, {31'd0, m_flush});
    check("redirect", redirect_pc, m_redir);
    check("resolved", {31'd0, resolved_taken}, {31'd0, m_taken});
`ifdef BRANCH_PERF_EN
    check("br_count", br_count, m_br);
    check("mispred_count", mispred_count, m_mis);
`endif
  endtask

  task automatic idle(input logic [31:0] fpc);
    step(0, 0, 3'd0, 32'h0, 32'h0, 0, 0, 0, 0, fpc);
  endtask

  initial begin
    rst_n = 1'b0;
    f_pc = 0; ex_valid = 0; ex_is_branch = 0; ex_funct3 = 0; ex_pc = 0;
    ex_target = 0; ex_pred_taken = 0; alu_zero = 0; alu_lt = 0; stall = 0;
    model_reset();
    repeat (2) @(negedge clk);
    f_pc = 32'h100;
    #1;
    check("rst_flush", {31'd0, flush}, 32'd0);
    check("rst_redirect", redirect_pc, 32'd0);
    check("rst_resolved", {31'd0, resolved_taken}, 32'd0);
    check("rst_pred", {31'd0, f_pred_taken}, 32'd0);
    rst_n = 1'b1;

    // BEQ mispredicted taken
    step(1, 1, 3'd0, 32'h100, 32'h140, 0, 1, 0, 0, 32'h100);
    check("beq_flush", {31'd0, flush}, 32'd1);
    check("beq_redirect", redirect_pc, 32'h140);
    idle(32'h100);
    check("beq_trained", {31'd0, f_pred_taken}, 32'd1);

    // BNE predicted taken but not taken
    step(1, 1, 3'd1, 32'h200, 32'h280, 1, 1, 0, 0, 32'h200);
    check("bne_redirect", redirect_pc, 32'h204);
    idle(32'h200);

    // BLT trained to saturation, then one not-taken
    for (int k = 0; k < 5; k++) begin
      step(1, 1, 3'd4, 32'h300, 32'h3a0, m_ctr[tbl_idx(32'h300)] >= 2, 0, 1, 0, 32'h300);
      idle(32'h300);
    end
    check("blt_sat", m_ctr[tbl_idx(32'h300)], 3);
    step(1, 1, 3'd4, 32'h300, 32'h3a0, 1, 0, 0, 0, 32'h300);
    idle(32'h300);
    check("blt_down_pred", {31'd0, f_pred_taken}, 32'd1);

    // Mispredicting BGE held by stall for 3 cycles
    for (int k = 0; k < 3; k++) begin
      step(1, 1, 3'd5, 32'h400, 32'h480, 0, 0, 0, 1, 32'h400);
      check("stall_noflush", {31'd0, flush}, 32'd0);
    end
    step(1, 1, 3'd5, 32'h400, 32'h480, 0, 0, 0, 0, 32'h400);
    check("stall_release_flush", {31'd0, flush}, 32'd1);
    idle(32'h400);
    check("stall_pulse_end", {31'd0, flush}, 32'd0);

    // Back-to-back mispredicts: second is wrong-path
    step(1, 1, 3'd0, 32'h500, 32'h600, 0, 1, 0, 0, 32'h540);
    step(1, 1, 3'd0, 32'h540, 32'h700, 0, 1, 0, 0, 32'h540);
    check("b2b_noflush", {31'd0, flush}, 32'd0);
    check("b2b_redirect", redirect_pc, 32'h600);
    idle(32'h540);

    // Reset in the middle of a flush pulse
    step(1, 1, 3'd1, 32'h100, 32'h180, 1, 1, 0, 0, 32'h100);
    check("pre_rst_flush", {31'd0, flush}, 32'd1);
    rst_n = 1'b0;
    f_pc = 32'h300;
    #1;
    model_reset();
    check("midrst_flush", {31'd0, flush}, 32'd0);
    check("midrst_pred", {31'd0, f_pred_taken}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic with index aliasing and same-cycle lookups
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] pc, tgt, fpc;
      bit pred;
      pc  = 32'h1000 + ($urandom_range(0, 7) << 2) + ($urandom_range(0, 1) << 8);
      tgt = $urandom;
      fpc = ($urandom_range(0, 1) == 1) ? pc : 32'h1000 + ($urandom_range(0, 15) << 2);
      pred = ($urandom_range(0, 9) < 7) ? (m_ctr[tbl_idx(pc)] >= 2) : 1'($urandom_range(0, 1));
      step($urandom_range(0, 9) != 0, $urandom_range(0, 6) != 0, 3'($urandom_range(0, 7)),
           pc, tgt, pred, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           $urandom_range(0, 4) == 0, fpc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
